// File: rtl/keycode_event_gen.sv
`default_nettype none
// ============================================================================
// Module   : keycode_event_gen
// Purpose  : Turns the level-held 8-bit keycode written by the Nios PIO
//            (0 = no key) into discrete key events: press, release and
//            typematic auto-repeat. Events are queued in a small show-ahead
//            FIFO and handed to the canvas/cursor logic over valid/ready.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: KEYCODE_EVT_SYNC_EN
//   defined   : keycode passes through a 2-flop synchronizer (reset to 0)
//               before change detection; keycode-to-evt_valid latency is 3.
//   undefined : keycode is used directly; latency is 1.
// ----------------------------------------------------------------------------
// Parameters
//   FIFO_DEPTH    event FIFO entries (power of 2, >= 2)
//   REPEAT_DELAY  cycles a key is held before the first repeat (>= 1)
//   REPEAT_PERIOD cycles between subsequent repeats (>= 1)
//   CNT_W         repeat counter width, holds max(REPEAT_DELAY,REPEAT_PERIOD)
// Ports
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   keycode       current keycode from the PIO, 0 = none
//   evt_ready     consumer accepts the head event
//   evt_valid     FIFO non-empty
//   evt_code      keycode of the head event
//   evt_press     1 = press/repeat, 0 = release
//   evt_repeat    1 = auto-repeat press
//   fifo_level    number of stored events
//   overflow      sticky: an event was dropped because the FIFO was full
//   overflow_clr  clears overflow (a same-cycle drop wins)
// ============================================================================
module keycode_event_gen #(
  parameter int FIFO_DEPTH    = 4,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000,
  parameter int CNT_W         = 25
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [7:0]                    keycode,
  input  logic                          evt_ready,
  output logic                          evt_valid,
  output logic [7:0]                    evt_code,
  output logic                          evt_press,
  output logic                          evt_repeat,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          overflow_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [LW-1:0]    DEPTH_L     = LW'(FIFO_DEPTH);

  // --------------------------------------------------------------------------
  // Keycode input stage
  // --------------------------------------------------------------------------
  logic [7:0] key_s;

`ifdef KEYCODE_EVT_SYNC_EN
  logic [7:0] sync_q1;
  logic [7:0] sync_q2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= 8'd0;
      sync_q2 <= 8'd0;
    end else begin
      sync_q1 <= keycode;
      sync_q2 <= sync_q1;
    end
  end

  assign key_s = sync_q2;
`else
  assign key_s = keycode;
`endif

  // --------------------------------------------------------------------------
  // Change detection and repeat FSM
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RPT  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       prev_code;
  logic [7:0]       prev_code_nxt;
  logic             pend;
  logic             pend_nxt;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] counter_nxt;
  logic             rpt_hit;
  logic             push;
  logic [9:0]       push_evt;   // {code[7:0], press, repeat}

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      prev_code <= 8'd0;
      pend      <= 1'b0;
      counter   <= '0;
    end else begin
      state     <= state_nxt;
      prev_code <= prev_code_nxt;
      pend      <= pend_nxt;
      counter   <= counter_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    prev_code_nxt = prev_code;
    pend_nxt      = pend;
    counter_nxt   = counter;
    rpt_hit       = 1'b0;
    push          = 1'b0;
    push_evt      = 10'd0;

    // Repeat timing. The FSM still advances when its push is later
    // overridden by a change or deferred press, so the schedule is kept.
    case (state)
      ST_IDLE: begin
        counter_nxt = '0;
      end
      ST_HOLD: begin
        if (counter == DELAY_LAST) begin
          rpt_hit     = 1'b1;
          counter_nxt = '0;
          state_nxt   = ST_RPT;
        end else begin
          counter_nxt = counter + CNT_W'(1);
        end
      end
      ST_RPT: begin
        if (counter == PERIOD_LAST) begin
          rpt_hit     = 1'b1;
          counter_nxt = '0;
        end else begin
          counter_nxt = counter + CNT_W'(1);
        end
      end
      default: begin
        state_nxt   = ST_IDLE;
        counter_nxt = '0;
      end
    endcase

    if (rpt_hit) begin
      push     = 1'b1;
      push_evt = {prev_code, 1'b1, 1'b1};
    end

    // Later assignments override the repeat push: change traffic has
    // priority over auto-repeat.
    if (pend) begin
      // Deferred press of a key that replaced another key directly;
      // prev_code already holds the new key.
      push     = 1'b1;
      push_evt = {prev_code, 1'b1, 1'b0};
      pend_nxt = 1'b0;
    end else if (key_s != prev_code) begin
      prev_code_nxt = key_s;
      counter_nxt   = '0;
      state_nxt     = (key_s != 8'd0) ? ST_HOLD : ST_IDLE;
      if (prev_code != 8'd0) begin
        push     = 1'b1;
        push_evt = {prev_code, 1'b0, 1'b0};
        pend_nxt = (key_s != 8'd0);
      end else begin
        push     = 1'b1;
        push_evt = {key_s, 1'b1, 1'b0};
      end
    end
  end

  // --------------------------------------------------------------------------
  // Event FIFO (show-ahead, head read straight from storage)
  // --------------------------------------------------------------------------
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          full;
  logic          pop;
  logic          wr_en;
  logic          drop;

  assign full  = (level == DEPTH_L);
  assign pop   = evt_valid & evt_ready;
  // A pop in the same cycle frees the slot for the incoming event.
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= 10'd0;
      end
    end else if (wr_en) begin
      mem[wr_ptr] <= push_evt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

  assign evt_valid                          = (level != '0);
  assign {evt_code, evt_press, evt_repeat}  = mem[rd_ptr];
  assign fifo_level                         = level;

endmodule

`default_nettype wire

// File: tb/tb_keycode_event_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_keycode_event_gen
// Purpose  : Self-checking bench for keycode_event_gen. A queue-based event
//            model derived from key hold time is compared against the DUT on
//            every cycle; directed sequences add hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keycode_event_gen;

  localparam int DEPTH  = 4;
  localparam int DELAY  = 10;
  localparam int PERIOD = 4;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [7:0]    keycode = 8'd0;
  logic          evt_ready = 1'b1;
  logic          overflow_clr = 1'b0;
  logic          evt_valid;
  logic [7:0]    evt_code;
  logic          evt_press;
  logic          evt_repeat;
  logic [LW-1:0] fifo_level;
  logic          overflow;

  int checks   = 0;
  int failures = 0;

  keycode_event_gen #(
    .FIFO_DEPTH   (DEPTH),
    .REPEAT_DELAY (DELAY),
    .REPEAT_PERIOD(PERIOD),
    .CNT_W        (25)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .keycode     (keycode),
    .evt_ready   (evt_ready),
    .evt_valid   (evt_valid),
    .evt_code    (evt_code),
    .evt_press   (evt_press),
    .evt_repeat  (evt_repeat),
    .fifo_level  (fifo_level),
    .overflow    (overflow),
    .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Model: key state tracked by hold age, events kept in a queue
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [7:0] code;
    logic       press;
    logic       rep;
  } evt_t;

  evt_t       mq[$];
  logic [7:0] m_prev = 8'd0;
  bit         m_pend = 1'b0;
  int         m_age  = 0;
  bit         m_ovf  = 1'b0;

  task automatic model_clear();
    mq.delete();
    m_prev = 8'd0;
    m_pend = 1'b0;
    m_age  = 0;
    m_ovf  = 1'b0;
  endtask

  task automatic model_step();
    evt_t p;
    bit   has_p;
    bit   rpt_due;
    bit   pop;
    bit   drop;
    has_p = 1'b0;
    drop  = 1'b0;
    p     = '0;
    // Repeats fall at hold age DELAY-1, then every PERIOD cycles after.
    rpt_due = (m_prev != 8'd0) &&
              ((m_age == DELAY - 1) ||
               ((m_age > DELAY - 1) && ((m_age - (DELAY - 1)) % PERIOD == 0)));
    if (m_pend) begin
      p      = '{code: m_prev, press: 1'b1, rep: 1'b0};
      has_p  = 1'b1;
      m_pend = 1'b0;
      m_age++;
    end else if (keycode != m_prev) begin
      if (m_prev != 8'd0) begin
        p = '{code: m_prev, press: 1'b0, rep: 1'b0};
        if (keycode != 8'd0) m_pend = 1'b1;
      end else begin
        p = '{code: keycode, press: 1'b1, rep: 1'b0};
      end
      has_p  = 1'b1;
      m_prev = keycode;
      m_age  = 0;
    end else begin
      if (rpt_due) begin
        p     = '{code: m_prev, press: 1'b1, rep: 1'b1};
        has_p = 1'b1;
      end
      m_age++;
    end
    pop = (mq.size() != 0) && evt_ready;
    if (pop) void'(mq.pop_front());
    if (has_p) begin
      if (mq.size() < DEPTH) mq.push_back(p);
      else drop = 1'b1;
    end
    m_ovf = drop ? 1'b1 : (overflow_clr ? 1'b0 : m_ovf);
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_clear();
      else model_step();
    end
  end

  // Compare every cycle on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      chk("cmp_valid", {31'd0, evt_valid}, {31'd0, mq.size() != 0});
      chk("cmp_level", {{(32-LW){1'b0}}, fifo_level}, mq.size());
      chk("cmp_overflow", {31'd0, overflow}, {31'd0, m_ovf});
      if (mq.size() != 0) begin
        chk("cmp_code", {24'd0, evt_code}, {24'd0, mq[0].code});
        chk("cmp_press", {31'd0, evt_press}, {31'd0, mq[0].press});
        chk("cmp_repeat", {31'd0, evt_repeat}, {31'd0, mq[0].rep});
      end
    end
  end

  // --------------------------------------------------------------------------
  // Directed stimulus
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string name, input logic [7:0] code, input logic press, input logic rep);
    chk({name, "_valid"}, {31'd0, evt_valid}, 32'd1);
    chk({name, "_code"}, {24'd0, evt_code}, {24'd0, code});
    chk({name, "_press"}, {31'd0, evt_press}, {31'd0, press});
    chk({name, "_rep"}, {31'd0, evt_repeat}, {31'd0, rep});
  endtask

  // Ticks until evt_valid rises; returns the number of ticks taken.
  task automatic wait_evt(output int n);
    n = 0;
    while (!evt_valid && n < 40) begin
      tick();
      n++;
    end
    if (!evt_valid) chk("wait_evt_timeout", {31'd0, evt_valid}, 32'd1);
  endtask

  int n;
  int cnt;
  evt_t drain_exp [4];

  initial begin
    repeat (3) tick();
    chk("rst_valid", {31'd0, evt_valid}, 32'd0);
    chk("rst_level", {{(32-LW){1'b0}}, fifo_level}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_code", {24'd0, evt_code}, 32'd0);
    chk("rst_press", {31'd0, evt_press}, 32'd0);
    chk("rst_repeat", {31'd0, evt_repeat}, 32'd0);
    reset_n = 1'b1;
    repeat (4) tick();
    chk("idle_valid", {31'd0, evt_valid}, 32'd0);

    // Press, first repeat after DELAY cycles, then every PERIOD cycles
    keycode = 8'h1A;
    tick();
    chk_head("press1a", 8'h1A, 1'b1, 1'b0);
    tick();
    chk("press1a_popped", {31'd0, evt_valid}, 32'd0);
    wait_evt(n);
    chk("first_rpt_gap", n, 32'd9);
    chk_head("rpt1", 8'h1A, 1'b1, 1'b1);
    tick();
    wait_evt(n);
    chk("rpt_period_gap", n, 32'd3);
    chk_head("rpt2", 8'h1A, 1'b1, 1'b1);

    // Direct key change: release of old, then deferred press of new
    keycode = 8'h16;
    tick();
    chk_head("rel1a", 8'h1A, 1'b0, 1'b0);
    tick();
    chk_head("press16", 8'h16, 1'b1, 1'b0);
    tick();
    wait_evt(n);
    chk("chg_first_rpt_gap", n, 32'd8);
    chk_head("rpt16", 8'h16, 1'b1, 1'b1);
    tick();
    wait_evt(n);
    chk("chg_rpt_period_gap", n, 32'd3);

    // Release: exactly one event, then silence
    keycode = 8'h00;
    tick();
    chk_head("rel16", 8'h16, 1'b0, 1'b0);
    cnt = 0;
    repeat (20) begin
      tick();
      if (evt_valid) cnt++;
    end
    chk("idle_after_release_events", cnt, 32'd0);

    // Overflow: five events into a four-entry FIFO with no consumer
    evt_ready = 1'b0;
    keycode = 8'h21; tick();
    keycode = 8'h00; tick();
    keycode = 8'h22; tick();
    keycode = 8'h23; tick();
    tick();
    chk("ovf_level", {{(32-LW){1'b0}}, fifo_level}, 32'd4);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    keycode = 8'h00; tick();
    drain_exp[0] = '{code: 8'h21, press: 1'b1, rep: 1'b0};
    drain_exp[1] = '{code: 8'h21, press: 1'b0, rep: 1'b0};
    drain_exp[2] = '{code: 8'h22, press: 1'b1, rep: 1'b0};
    drain_exp[3] = '{code: 8'h22, press: 1'b0, rep: 1'b0};
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_head("drain", drain_exp[i].code, drain_exp[i].press, drain_exp[i].rep);
      tick();
    end
    chk("drain_empty", {31'd0, evt_valid}, 32'd0);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    overflow_clr = 1'b1; tick();
    overflow_clr = 1'b0;
    chk("ovf_cleared", {31'd0, overflow}, 32'd0);

    // Full FIFO with simultaneous pop and push
    evt_ready = 1'b0;
    keycode = 8'h31; tick();
    keycode = 8'h00; tick();
    keycode = 8'h32; tick();
    keycode = 8'h00; tick();
    chk("full_level", {{(32-LW){1'b0}}, fifo_level}, 32'd4);
    keycode = 8'h33;
    evt_ready = 1'b1;
    tick();
    chk("poppush_level", {{(32-LW){1'b0}}, fifo_level}, 32'd4);
    chk("poppush_ovf", {31'd0, overflow}, 32'd0);
    chk_head("poppush_head", 8'h31, 1'b0, 1'b0);
    repeat (4) tick();
    chk("poppush_drained", {31'd0, evt_valid}, 32'd0);

    // Reset while events are queued and a key is held
    evt_ready = 1'b0;
    keycode = 8'h34;
    tick();
    tick();
    chk("preq_level", {{(32-LW){1'b0}}, fifo_level}, 32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, evt_valid}, 32'd0);
    chk("async_rst_level", {{(32-LW){1'b0}}, fifo_level}, 32'd0);
    chk("async_rst_code", {24'd0, evt_code}, 32'd0);
    chk("async_rst_press", {31'd0, evt_press}, 32'd0);
    keycode = 8'h1A;
    evt_ready = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();
    chk_head("post_rst_press", 8'h1A, 1'b1, 1'b0);
    keycode = 8'h00;
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
